// File: rtl/mult_div_unit_pkg.sv
// Shared datapath definitions: ALU control codes, status bit indices
// and multiply/divide operation codes.
package mult_div_unit_pkg;

    // Status nibble layout shared with the ALU.
    localparam int STATUS_C_BIT = 0;
    localparam int STATUS_Z_BIT = 1;
    localparam int STATUS_N_BIT = 2;
    localparam int STATUS_V_BIT = 3;

    // ALU control codes.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;

    // Multiply/divide operation codes.
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // True for the iterative (multi-cycle) operations.
    function automatic logic md_is_iter(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide share one accumulator.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [3:0]            so
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          div_q, div_d;
    logic          neg_q, neg_d;
    logic          rneg_q, rneg_d;
    logic          bzero_q, bzero_d;
    logic [W-1:0]  araw_q, araw_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [3:0]    so_q, so_d;
    logic          done_q, done_d;

    logic          sgn, sa, sb;
    logic [W-1:0]  abs_a, abs_b;
    logic [W:0]    msum;
    logic [2*W-1:0] mul_nxt;
    logic [W:0]    rsh, dsub;
    logic          ge;
    logic [2*W-1:0] div_nxt;
    logic [2*W-1:0] prod;
    logic [W-1:0]  quot, rem;
    logic [W-1:0]  fix_hi, fix_lo;
    logic          fix_v, fix_n;

    // Operand magnitudes and sign info for the incoming request.
    always_comb begin
        sgn   = (op == MD_MULT) || (op == MD_DIV);
        sa    = sgn & a[W-1];
        sb    = sgn & b[W-1];
        abs_a = sa ? -a : a;
        abs_b = sb ? -b : b;
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        msum    = {1'b0, acc_q[2*W-1:W]}
                + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {msum, acc_q[W-1:1]};
        rsh     = {acc_q[2*W-1:W], acc_q[W-1]};
        ge      = rsh >= {1'b0, opnd_q};
        dsub    = rsh - {1'b0, opnd_q};
        div_nxt = {(ge ? dsub[W-1:0] : rsh[W-1:0]), acc_q[W-2:0], ge};
    end

    // Sign correction and status for the final write-back.
    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        quot   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem    = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        fix_v  = 1'b0;
        fix_hi = prod[2*W-1:W];
        fix_lo = prod[W-1:0];
        if (div_q) begin
            if (bzero_q) begin
                fix_hi = araw_q;
                fix_lo = '1;
                fix_v  = 1'b1;
            end else begin
                fix_hi = rem;
                fix_lo = quot;
            end
        end
        fix_n = div_q ? fix_lo[W-1] : fix_hi[W-1];
    end

    // FSM and next-state for working and result registers.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        araw_d  = araw_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        so_d    = so_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (md_is_iter(op)) begin
                        div_d   = (op == MD_DIV) || (op == MD_DIVU);
                        neg_d   = sa ^ sb;
                        rneg_d  = sa;
                        bzero_d = (b == '0);
                        araw_d  = a;
                        opnd_d  = div_d ? abs_b : abs_a;
                        acc_d   = {{W{1'b0}}, (div_d ? abs_a : abs_b)};
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else if (op == MD_MTHI) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (op == MD_MTLO) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                acc_d = div_q ? div_nxt : mul_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d = fix_hi;
                lo_d = fix_lo;
                so_d = '0;
                so_d[STATUS_V_BIT] = fix_v;
                so_d[STATUS_N_BIT] = fix_n;
                so_d[STATUS_Z_BIT] = (fix_hi == '0) && (fix_lo == '0);
                so_d[STATUS_C_BIT] = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            araw_q  <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            so_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            araw_q  <= araw_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign so   = so_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (DATA_WIDTH=32).
// Reference results come from native 64-bit arithmetic.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic [3:0]   so;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [3:0]   so;
    } res_t;

    res_t sb_q[$];
    int checks = 0;
    int failures = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [3:0]   m_so = '0;

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .so(so)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: updates architectural HI/LO/status, queues result.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        longint sx, sy;
        logic [63:0] p;
        logic v, n, md;
        res_t r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v  = 1'b0;
        md = 1'b1;
        case (o)
            MD_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MD_MULT: begin
                p = 64'(sx * sy);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MD_DIVU: begin
                if (y == 0) begin
                    m_hi = x; m_lo = '1; v = 1'b1;
                end else begin
                    m_lo = x / y; m_hi = x % y;
                end
            end
            MD_DIV: begin
                if (y == 0) begin
                    m_hi = x; m_lo = '1; v = 1'b1;
                end else begin
                    p = 64'(sx / sy); m_lo = p[31:0];
                    p = 64'(sx % sy); m_hi = p[31:0];
                end
            end
            MD_MTHI: begin m_hi = x; md = 1'b0; end
            MD_MTLO: begin m_lo = x; md = 1'b0; end
            default: md = 1'b0;
        endcase
        if (md) begin
            n = (o == MD_DIV || o == MD_DIVU) ? m_lo[W-1] : m_hi[W-1];
            m_so = '0;
            m_so[STATUS_V_BIT] = v;
            m_so[STATUS_N_BIT] = n;
            m_so[STATUS_Z_BIT] = (m_hi == 0) && (m_lo == 0);
        end
        r.hi = m_hi; r.lo = m_lo; r.so = m_so;
        sb_q.push_back(r);
    endtask

    // Issue one op, watch handshake timing, compare against scoreboard.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit inject);
        logic [W-1:0] ph, pl;
        bit md, seen;
        int n, nbusy;
        res_t r;
        md = md_is_iter(o);
        model(o, x, y);
        ph = hi;
        pl = lo;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        nbusy = busy ? 1 : 0;
        seen = done;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (inject && n == 10) begin
                start = 1'b1; op = MD_MTHI; a = 32'hdead_beef;
            end else if (inject && n == 11) begin
                start = 1'b0;
            end
            if (md && n == 16) begin
                check("hold_hi", hi, ph);
                check("hold_lo", lo, pl);
            end
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
        if (!seen) check("timeout", 0, 1);
        r = sb_q.pop_front();
        check("hi", hi, r.hi);
        check("lo", lo, r.lo);
        check("so", so, r.so);
        check("latency", n, md ? 33 : 0);
        check("busy_cycles", nbusy, md ? 33 : 0);
        check("busy_at_done", busy, 0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_so", so, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(MD_MULTU, 32'hffff_ffff, 32'hffff_ffff, 1'b0);
        do_op(MD_MULT,  32'hffff_fffd, 32'd7, 1'b0);
        do_op(MD_DIV,   32'hffff_fff9, 32'd2, 1'b0);
        do_op(MD_DIV,   32'h8000_0000, 32'hffff_ffff, 1'b0);
        do_op(MD_DIVU,  32'h0000_0abc, 32'd0, 1'b0);
        do_op(MD_MTHI,  32'h0000_1234, 32'd0, 1'b0);
        do_op(MD_MTLO,  32'h0000_5678, 32'd0, 1'b0);
        do_op(MD_MULTU, 32'h1234_5678, 32'h9abc_def0, 1'b1);
        do_op(MD_DIV,   32'd100, 32'hffff_fff9, 1'b0);
        do_op(MD_MULT,  32'd0, 32'h8000_0000, 1'b0);

        // Unknown op code must be ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = 32'h1; b = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        check("unk_busy", busy, 0);
        check("unk_done", done, 0);
        check("unk_hi", hi, m_hi);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] ro;
            logic [W-1:0] rb;
            ro = 3'($urandom_range(0, 3));
            rb = $urandom;
            if (ro >= MD_DIV) rb = 32'($urandom_range(0, 1000));
            do_op(ro, $urandom, rb, 1'b0);
        end

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; op = MD_MULTU; a = 32'hffff_ffff; b = 32'h3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_so", so, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0; m_so = '0;
        do_op(MD_MULTU, 32'd6, 32'd7, 1'b0);
        check("post_rst_lo", lo, 32'h2a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
